// File: rtl/mux41_rr.sv
// mux41_rr: 4:1 round-robin valid/ready mux with a registered output stage.
// Define MUX41_LAST_EN to add in_last/out_last and lock the grant to a channel until its last beat.
module mux41_rr #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]    in_ready,
`ifdef MUX41_LAST_EN
  input  logic [3:0]    in_last,
  output logic          out_last,
`endif
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_sel,
  input  logic          out_ready
);
  logic [1:0] ptr;
  logic [1:0] gnt;
  logic       gnt_any;
  logic       slot_free;
`ifdef MUX41_LAST_EN
  logic       lock;
`endif
  assign slot_free = !out_valid || out_ready;
  // Scan from farthest to nearest so the channel closest after ptr wins.
  always_comb begin
    gnt = 2'd0;
    gnt_any = 1'b0;
    for (int i = 4; i >= 1; i--)
      if (in_valid[ptr + 2'(i)]) begin
        gnt = ptr + 2'(i);
        gnt_any = 1'b1;
      end
`ifdef MUX41_LAST_EN
    // While locked, out_sel still names the channel whose packet is open.
    if (lock) begin
      gnt = out_sel;
      gnt_any = in_valid[out_sel];
    end
`endif
  end
  assign in_ready = (slot_free && gnt_any && !rst) ? 4'b0001 << gnt : 4'b0000;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      ptr       <= 2'd3;
`ifdef MUX41_LAST_EN
      out_last  <= 1'b0;
      lock      <= 1'b0;
`endif
    end else if (slot_free) begin
      out_valid <= gnt_any;
      if (gnt_any) begin
        out_data <= in_data[32'(gnt)*DW +: DW];
        out_sel  <= gnt;
        ptr      <= gnt;
`ifdef MUX41_LAST_EN
        out_last <= in_last[gnt];
        lock     <= !in_last[gnt];
`endif
      end
    end
endmodule

// File: tb/tb_mux41_rr.sv
// tb_mux41_rr: randomized scoreboard bench for mux41_rr against a round-robin reference model.
module tb_mux41_rr;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] in_valid = 4'b0;
  logic [4*DW-1:0] in_data = '0;
  logic [3:0] in_ready;
  logic out_valid;
  logic [DW-1:0] out_data;
  logic [1:0] out_sel;
  logic out_ready = 1'b0;
  logic lst;
`ifdef MUX41_LAST_EN
  logic [3:0] in_last = 4'b0;
  logic out_last;
  assign lst = out_last;
`else
  assign lst = 1'b0;
`endif
  int tests = 0;
  int fails = 0;
  logic [DW+2:0] q[$];
  int mptr;
  int g;
  logic mvalid;
  logic slot;
  logic mlock;
  int mlch;
  logic exp_last;
  logic [DW+2:0] e;

  mux41_rr #(.DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
`ifdef MUX41_LAST_EN
    .in_last(in_last),
    .out_last(out_last),
`endif
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endfunction

  function automatic int pick(logic [3:0] v, int p);
    for (int off = 1; off <= 4; off++)
      if (v[(p + off) % 4]) return (p + off) % 4;
    return -1;
  endfunction

  // Reference model: predicts this cycle's grant and queues the beat it should produce.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mptr = 3;
      mvalid = 1'b0;
      mlock = 1'b0;
      mlch = 0;
    end else begin
      slot = !mvalid || out_ready;
      g = pick(in_valid, mptr);
      if (mlock) g = in_valid[mlch] ? mlch : -1;
      chk("out_valid", 32'(out_valid), 32'(mvalid));
      chk("in_ready", 32'(in_ready), (slot && g >= 0) ? 32'(1) << g : 32'd0);
      if (slot && g >= 0) begin
`ifdef MUX41_LAST_EN
        exp_last = in_last[g];
        mlock = !in_last[g];
        mlch = g;
`else
        exp_last = 1'b0;
`endif
        q.push_back({exp_last, 2'(g), in_data[g*DW +: DW]});
        mvalid = 1'b1;
        mptr = g;
      end else if (slot) mvalid = 1'b0;
    end
  end

  // Monitor: every accepted output beat must match the oldest predicted beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("beat_unexpected", 32'(out_sel), 32'hffff_ffff);
      else begin
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e[DW-1:0]));
        chk("out_sel", 32'(out_sel), 32'(e[DW+1:DW]));
        chk("out_last", 32'(lst), 32'(e[DW+2]));
      end
    end
  end

  task automatic cyc(input logic [3:0] v, input logic r, input logic [31:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    out_ready = r;
    in_data = d;
`ifdef MUX41_LAST_EN
    in_last = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
`endif
  endtask

  initial begin
    in_valid = 4'b1111;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 4'b0100;
    in_data = 32'h00A5_0000;
    out_ready = 1'b1;
    #1;
    chk("first_in_ready", 32'(in_ready), 32'h4);
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b1, $urandom);
    for (int i = 0; i < 8; i++) cyc(4'b1111, 1'b1, $urandom);
    cyc(4'b0000, 1'b1, $urandom);
    cyc(4'b0001, 1'b0, 32'h0000_003C);
    for (int i = 0; i < 5; i++) cyc(4'b1111, 1'b0, $urandom);
    chk("stall_data", 32'(out_data), 32'h3C);
    cyc(4'b1111, 1'b1, $urandom);
    for (int i = 0; i < 3; i++) cyc(4'b0010, 1'b1, $urandom);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(4'b1111, 1'b1, $urandom);
    for (int i = 0; i < 2000; i++) cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), $urandom);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b1, $urandom);
    @(negedge clk);
    chk("drain_queue", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux41_rr.md
MUX41_RR -- requirements
Module: mux41_rr

Interface
REQ-001 Parameter: DW, default 8, width of each data channel.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  4  per-channel beat-valid, bit k = channel k.
REQ-005 in_data  input  4*DW  channel k data on bits [k*DW +: DW].
REQ-006 in_ready  output  4  per-channel beat-accept, bit k = channel k.
REQ-007 out_valid  output  1  registered output beat valid.
REQ-008 out_data  output  DW  registered output data.
REQ-009 out_sel  output  2  source channel index of the current out_data, usable as the select input of a downstream 1:4 demux.
REQ-010 out_ready  input  1  downstream accept.

Function
REQ-011 A transfer occurs on a channel when in_valid[k] and in_ready[k] are both 1 at a rising edge; an output transfer occurs when out_valid and out_ready are both 1.
REQ-012 The output register shall be loadable when out_valid==0 or out_ready==1 (load = "slot free").
REQ-013 Arbitration shall be combinational round-robin: starting at channel (ptr+1) mod 4 and wrapping upward, the first channel with in_valid=1 is granted.
REQ-014 in_ready[k] shall be 1 only when slot free and k is the granted channel; at most one bit of in_ready is 1 in any cycle; in_ready is 0 when no input is valid.
REQ-015 On an input transfer from channel k: out_data <= channel k data, out_sel <= k, out_valid <= 1, ptr <= k.
REQ-016 If slot free and no input transfer occurs, out_valid <= 0; out_data and out_sel hold.
REQ-017 If out_valid==1 and out_ready==0, out_valid, out_data and out_sel shall hold unchanged and in_ready shall be 4'b0000.
REQ-018 Latency: one cycle from input transfer to out_valid; sustained throughput one beat per cycle with out_ready held 1.
REQ-019 Simultaneous output transfer and new input transfer in the same cycle shall replace the register contents with no bubble.
REQ-020 in_valid deasserted by a source without a transfer shall not be treated as an error; arbitration re-evaluates every cycle.
REQ-021 With all four channels continuously valid and out_ready=1, grants shall rotate 0,1,2,3,0,... (from reset).

Reset
REQ-022 While rst=1: out_valid=0, out_data=0, out_sel=0, ptr=3 (channel 0 highest priority first), lock state cleared, in_ready=4'b0000.
REQ-023 Reset asserted mid-operation shall discard any held output beat immediately, without waiting for a clock edge.
REQ-024 After rst deasserts, the first transfer shall be possible at the first rising edge.

Configuration
REQ-025 Macro MUX41_LAST_EN: when defined, ports in_last (input, 4) and out_last (output, 1) are added; out_last is registered with out_data; after a transfer from channel k with in_last[k]=0 the grant is locked to k (other channels get in_ready=0 even if k is idle) until a transfer from k with in_last[k]=1, which clears the lock and sets ptr=k.
REQ-026 Without MUX41_LAST_EN: no last ports exist; arbitration is per-beat per REQ-013.
REQ-027 Reset clears the lock and out_last to 0.

Verification
REQ-028 Reset, in_valid=4'b0100, data2=8'hA5, out_ready=1 -> in_ready=4'b0100 in cycle 0; next cycle out_valid=1, out_data=A5, out_sel=2.
REQ-029 All in_valid=4'b1111, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, no idle cycle.
REQ-030 out_valid=1 with out_data=8'h3C, out_ready=0 for 5 cycles, in_valid=4'b1111 -> out_data stays 3C, in_ready=0 throughout; first cycle with out_ready=1 accepts the next granted channel.
REQ-031 Streaming on channel 1 (ptr=1), assert rst asynchronously mid-cycle -> out_valid falls to 0 before the next edge; after release, channel 0 is granted first.
REQ-032 MUX41_LAST_EN: channel 3 sends 3 beats (last on third) with in_valid=4'b1111 -> out_sel 3,3,3 then 0; out_last=1 only on the third beat.
REQ-033 in_valid=4'b0000 for 3 cycles with out_ready=1 -> out_valid=0, in_ready=0, ptr unchanged.
